// File: rtl/baccarat_pkg.sv
// Shared state encoding and scoring constants for the baccarat deal sequencer.
// The optional STATE_DBG_EN build exposes the state encoding defined here.
package baccarat_pkg;

    typedef enum logic [3:0] {
        S_P1   = 4'd0,
        S_D1   = 4'd1,
        S_P2   = 4'd2,
        S_D2   = 4'd3,
        S_CHK  = 4'd4,
        S_P3   = 4'd5,
        S_CHK3 = 4'd6,
        S_D3   = 4'd7,
        S_FIN  = 4'd8
    } state_t;

    localparam logic [3:0] NATURAL_MIN = 4'd8;
    localparam logic [3:0] FACE_MIN    = 4'd10;

    function automatic logic is_natural(input logic [3:0] p, input logic [3:0] d);
        return (p >= NATURAL_MIN) || (d >= NATURAL_MIN);
    endfunction

endpackage

// File: rtl/banker_rule.sv
// Banker third-card tableau: decides whether the dealer draws given its
// two-card score and the value of the player's third card.
module banker_rule (
    input  logic [3:0] dscore,
    input  logic [3:0] v,
    output logic       draw
);

    always_comb begin
        draw = 1'b0;
        case (dscore)
            4'd0, 4'd1, 4'd2: draw = 1'b1;
            4'd3:             draw = (v != 4'd8);
            4'd4:             draw = (v >= 4'd2) && (v <= 4'd7);
            4'd5:             draw = (v >= 4'd4) && (v <= 4'd7);
            4'd6:             draw = (v >= 4'd6) && (v <= 4'd7);
            default:          draw = 1'b0;
        endcase
    end

endmodule

// File: rtl/deal_sequencer.sv
// Moore controller that deals a baccarat hand and lights the winner.
// Define STATE_DBG_EN to add the state_dbg output carrying the state encoding.
module deal_sequencer
    import baccarat_pkg::*;
(
    input  logic       slow_clock,
    input  logic       resetb,
    input  logic [3:0] pscore,
    input  logic [3:0] dscore,
    input  logic [3:0] pcard3,
    output logic       load_pcard1,
    output logic       load_pcard2,
    output logic       load_pcard3,
    output logic       load_dcard1,
    output logic       load_dcard2,
    output logic       load_dcard3,
    output logic       player_win_light,
    output logic       dealer_win_light,
`ifdef STATE_DBG_EN
    output logic [3:0] state_dbg,
`endif
    output logic       hand_done
);

    state_t     state;
    state_t     state_nxt;
    logic [3:0] v;
    logic       draw;

    // Face cards and tens count as zero toward the banker rule.
    assign v = (pcard3 >= FACE_MIN) ? 4'd0 : pcard3;

    banker_rule u_banker_rule (
        .dscore (dscore),
        .v      (v),
        .draw   (draw)
    );

    always_ff @(posedge slow_clock or negedge resetb) begin
        if (!resetb) begin
            state <= S_P1;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_P1:   state_nxt = S_D1;
            S_D1:   state_nxt = S_P2;
            S_P2:   state_nxt = S_D2;
            S_D2:   state_nxt = S_CHK;
            S_CHK: begin
                if (is_natural(pscore, dscore)) begin
                    state_nxt = S_FIN;
                end else if (pscore <= 4'd5) begin
                    state_nxt = S_P3;
                end else if (dscore <= 4'd5) begin
                    state_nxt = S_D3;
                end else begin
                    state_nxt = S_FIN;
                end
            end
            // Decide only after the player's third card has settled into the scores.
            S_P3:   state_nxt = S_CHK3;
            S_CHK3: state_nxt = draw ? S_D3 : S_FIN;
            S_D3:   state_nxt = S_FIN;
            S_FIN:  state_nxt = S_FIN;
            default: state_nxt = S_P1;
        endcase
    end

    always_comb begin
        load_pcard1      = (state == S_P1);
        load_dcard1      = (state == S_D1);
        load_pcard2      = (state == S_P2);
        load_dcard2      = (state == S_D2);
        load_pcard3      = (state == S_P3);
        load_dcard3      = (state == S_D3);
        hand_done        = (state == S_FIN);
        // A tie lights both indicators.
        player_win_light = (state == S_FIN) && (pscore >= dscore);
        dealer_win_light = (state == S_FIN) && (dscore >= pscore);
    end

`ifdef STATE_DBG_EN
    assign state_dbg = state;
`endif

endmodule
